// File: rtl/gtech_evt_capture5.sv
// gtech_evt_capture5: five-channel event capture with sticky pend/ovf flags, clear/mask ports, masked outputs Z*=PEND&~MSK
module gtech_evt_capture5 #(
  parameter bit         EDGE    = 1'b1,
  parameter logic [4:0] MSK_RST = 5'b11111
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       A,
  input  logic       B,
  input  logic       C,
  input  logic       D,
  input  logic       E,
  input  logic       CLR,
  input  logic [4:0] CLR_SEL,
  input  logic       MSK_WE,
  input  logic [4:0] MSK_D,
  output logic       ZA,
  output logic       ZB,
  output logic       ZC,
  output logic       ZD,
  output logic       ZE,
  output logic [4:0] PEND,
  output logic [4:0] OVF,
  output logic [4:0] MSK
);
  logic [4:0] in_w, evt, clr;
  logic [4:0] prev_q, prev_d, pend_q, pend_d, ovf_q, ovf_d, msk_q, msk_d;
  always_comb begin
    in_w   = {E, D, C, B, A};
    evt    = EDGE ? (in_w & ~prev_q) : in_w;
    clr    = {5{CLR}} & CLR_SEL;
    prev_d = in_w;
    pend_d = evt | (pend_q & ~clr);
    ovf_d  = (evt & pend_q & ~clr) | (ovf_q & ~clr);
    msk_d  = MSK_WE ? MSK_D : msk_q;
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      prev_q <= '0;
      pend_q <= '0;
      ovf_q  <= '0;
      msk_q  <= MSK_RST;
    end else begin
      prev_q <= prev_d;
      pend_q <= pend_d;
      ovf_q  <= ovf_d;
      msk_q  <= msk_d;
    end
  end
  assign {ZE, ZD, ZC, ZB, ZA} = pend_q & ~msk_q;
  assign PEND = pend_q;
  assign OVF  = ovf_q;
  assign MSK  = msk_q;
endmodule

// File: tb/tb_gtech_evt_capture5.sv
// tb_gtech_evt_capture5: random and directed checks of edge- and level-mode instances against a behavioural model
module tb_gtech_evt_capture5;
  logic       clk = 1'b0;
  logic       rst, clr, msk_we;
  logic [4:0] ev, clr_sel, msk_d;
  logic [4:0] pend [2];
  logic [4:0] ovf [2];
  logic [4:0] msk [2];
  logic [4:0] z [2];
  logic [4:0] m_prev [2];
  logic [4:0] m_pend [2];
  logic [4:0] m_ovf [2];
  logic [4:0] m_msk [2];
  bit         armed = 1'b0;
  int         vectors = 0;
  int         errors = 0;
  always #5 clk = ~clk;
  gtech_evt_capture5 #(.EDGE(1'b0), .MSK_RST(5'b11111)) u_lvl (
    .CLK(clk), .RST(rst), .A(ev[0]), .B(ev[1]), .C(ev[2]), .D(ev[3]), .E(ev[4]),
    .CLR(clr), .CLR_SEL(clr_sel), .MSK_WE(msk_we), .MSK_D(msk_d),
    .ZA(z[0][0]), .ZB(z[0][1]), .ZC(z[0][2]), .ZD(z[0][3]), .ZE(z[0][4]),
    .PEND(pend[0]), .OVF(ovf[0]), .MSK(msk[0]));
  gtech_evt_capture5 #(.EDGE(1'b1), .MSK_RST(5'b11111)) u_edg (
    .CLK(clk), .RST(rst), .A(ev[0]), .B(ev[1]), .C(ev[2]), .D(ev[3]), .E(ev[4]),
    .CLR(clr), .CLR_SEL(clr_sel), .MSK_WE(msk_we), .MSK_D(msk_d),
    .ZA(z[1][0]), .ZB(z[1][1]), .ZC(z[1][2]), .ZD(z[1][3]), .ZE(z[1][4]),
    .PEND(pend[1]), .OVF(ovf[1]), .MSK(msk[1]));
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m_prev[k] = '0;
        m_pend[k] = '0;
        m_ovf[k]  = '0;
        m_msk[k]  = 5'b11111;
      end else begin
        for (int ch = 0; ch < 5; ch++) begin
          bit in_b, ev_b, cl_b;
          in_b = ev[ch];
          ev_b = (k == 1) ? (in_b && !m_prev[k][ch]) : in_b;
          cl_b = clr && clr_sel[ch];
          if (ev_b && m_pend[k][ch] && !cl_b) m_ovf[k][ch] = 1'b1;
          else if (cl_b) m_ovf[k][ch] = 1'b0;
          if (ev_b) m_pend[k][ch] = 1'b1;
          else if (cl_b) m_pend[k][ch] = 1'b0;
          m_prev[k][ch] = in_b;
        end
        if (msk_we) m_msk[k] = msk_d;
      end
    end
    if (rst) armed = 1'b1;
  end
  always @(negedge clk) begin
    if (armed) begin
      for (int k = 0; k < 2; k++) begin
        logic [19:0] act, exp;
        act = {pend[k], ovf[k], msk[k], z[k]};
        exp = {m_pend[k], m_ovf[k], m_msk[k], m_pend[k] & ~m_msk[k]};
        vectors++;
        if (act !== exp) begin
          errors++;
          $display("FAIL model_cmp inst%0d t=%0t pend/ovf/msk/z got %b_%b_%b_%b want %b_%b_%b_%b", k, $time,
                   act[19:15], act[14:10], act[9:5], act[4:0], exp[19:15], exp[14:10], exp[9:5], exp[4:0]);
        end
      end
    end
  end
  task automatic tick();
    @(negedge clk);
  endtask
  task automatic chk(input string name, input logic [4:0] act, input logic [4:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %b want %b", name, act, exp);
    end
  endtask
  task automatic pin(input string name, input logic [4:0] dut_v, input logic [4:0] mdl_v, input logic [4:0] exp);
    chk({name, "_dut"}, dut_v, exp);
    chk({name, "_model"}, mdl_v, exp);
  endtask
  initial begin
    rst = 1'b1; clr = 1'b0; clr_sel = '0; msk_we = 1'b0; msk_d = '0; ev = 5'b11111;
    tick(); tick();
    pin("rst_pend", pend[1], m_pend[1], 5'b00000);
    pin("rst_ovf", ovf[1], m_ovf[1], 5'b00000);
    pin("rst_msk", msk[1], m_msk[1], 5'b11111);
    chk("rst_z", z[1], 5'b00000);
    rst = 1'b0; ev = 5'b00001;
    tick();
    pin("first_edge_pend", pend[1], m_pend[1], 5'b00001);
    chk("first_edge_z_masked", z[1], 5'b00000);
    ev = 5'b00000; msk_we = 1'b1; msk_d = 5'b00000;
    tick();
    msk_we = 1'b0;
    pin("unmask_msk", msk[1], m_msk[1], 5'b00000);
    chk("unmask_z", z[1], 5'b00001);
    clr = 1'b1; clr_sel = 5'b00001;
    tick();
    clr = 1'b0; clr_sel = '0;
    pin("clr_a", pend[1], m_pend[1], 5'b00000);
    ev = 5'b00100;
    tick();
    ev = 5'b00000;
    pin("pulse_c_pend", pend[1], m_pend[1], 5'b00100);
    chk("pulse_c_z", z[1], 5'b00100);
    tick();
    chk("held_c_z", z[1], 5'b00100);
    msk_we = 1'b1; msk_d = 5'b00100;
    tick();
    msk_we = 1'b0;
    chk("mask_c_z", z[1], 5'b00000);
    pin("mask_c_pend", pend[1], m_pend[1], 5'b00100);
    ev = 5'b10001;
    tick();
    ev = 5'b00000;
    tick();
    pin("pend_10101", pend[1], m_pend[1], 5'b10101);
    clr = 1'b1; clr_sel = 5'b00101;
    tick();
    clr = 1'b0; clr_sel = 5'b11111;
    pin("clr_sel_00101", pend[1], m_pend[1], 5'b10000);
    tick();
    clr_sel = '0;
    pin("clr_sel_no_strobe", pend[1], m_pend[1], 5'b10000);
    ev = 5'b00010;
    tick();
    ev = 5'b00000;
    tick();
    ev = 5'b00010; clr = 1'b1; clr_sel = 5'b00010;
    tick();
    ev = 5'b00000; clr = 1'b0; clr_sel = '0;
    pin("collide_pend", pend[1], m_pend[1], 5'b10010);
    pin("collide_ovf", ovf[1], m_ovf[1], 5'b00000);
    ev = 5'b01000;
    tick();
    ev = 5'b00000;
    tick();
    ev = 5'b01000;
    tick();
    ev = 5'b00000;
    pin("overrun_ovf", ovf[1], m_ovf[1], 5'b01000);
    clr = 1'b1; clr_sel = 5'b01000;
    tick();
    clr = 1'b0; clr_sel = '0;
    pin("overrun_clr_pend", pend[1], m_pend[1], 5'b10010);
    pin("overrun_clr_ovf", ovf[1], m_ovf[1], 5'b00000);
    rst = 1'b1; ev = 5'b00000;
    tick();
    rst = 1'b0; ev = 5'b10000;
    tick();
    pin("lvl_c1_pend", pend[0], m_pend[0], 5'b10000);
    pin("lvl_c1_ovf", ovf[0], m_ovf[0], 5'b00000);
    tick();
    pin("lvl_c2_ovf", ovf[0], m_ovf[0], 5'b10000);
    pin("edg_held_ovf", ovf[1], m_ovf[1], 5'b00000);
    tick();
    clr = 1'b1; clr_sel = 5'b10000;
    tick();
    clr = 1'b0; clr_sel = '0;
    pin("lvl_clr_held_pend", pend[0], m_pend[0], 5'b10000);
    pin("edg_clr_held_pend", pend[1], m_pend[1], 5'b00000);
    tick();
    pin("edg_no_reset_pend", pend[1], m_pend[1], 5'b00000);
    ev = 5'b00000;
    for (int n = 0; n < 400; n++) begin
      ev      = 5'($urandom);
      clr     = ($urandom_range(0, 2) == 0);
      clr_sel = 5'($urandom);
      msk_we  = ($urandom_range(0, 5) == 0);
      msk_d   = 5'($urandom);
      rst     = ($urandom_range(0, 40) == 0);
      tick();
    end
    rst = 1'b0; clr = 1'b0; msk_we = 1'b0; ev = '0;
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/gtech_evt_capture5.md
# gtech_evt_capture5

Five-channel synchronous event capture stage that sits directly upstream of the generic 5-input OR cell in the interrupt/event aggregation path. It detects events on five single-bit inputs and holds them in sticky pending flags. It applies a per-channel enable mask and drives the five masked pending bits, which the OR5 reduces to a single request line. Software-style clear and mask-write ports let the consumer acknowledge events without losing ones that arrive in the same cycle.

## Interface
- EDGE, 1, 1 = capture on rising edge of input; 0 = capture whenever input sampled high (level).
- MSK_RST, 5'b11111, reset value of the mask register (1 = channel masked).
- CLK  input  1  clock; all state updates on rising edge.
- RST  input  1  synchronous reset, active-high; one clock only, reset is synchronous and active-high.
- A, B, C, D, E  input  1 each  event inputs, synchronous to CLK; bit order {E,D,C,B,A} = [4:0].
- CLR  input  1  clear strobe.
- CLR_SEL  input  5  write-one-to-clear select, qualified by CLR.
- MSK_WE  input  1  mask write enable.
- MSK_D  input  5  new mask value, loaded when MSK_WE=1.
- ZA, ZB, ZC, ZD, ZE  output  1 each  masked pending (PEND[i] & ~MSK[i]); feeds the OR5.
- PEND  output  5  raw sticky pending flags.
- OVF  output  5  sticky overrun flags.
- MSK  output  5  current mask register.

## Operation
- Per channel i, state: PREV[i] (input sampled last edge), PEND[i], OVF[i]; shared MSK[4:0].
- Event detect at edge k:
  - EDGE=1: evt[i] = in[i] & ~PREV[i].
  - EDGE=0: evt[i] = in[i].
  - PREV[i] <= in[i] every non-reset edge.
- Clear request: clr[i] = CLR & CLR_SEL[i]; CLR_SEL is ignored when CLR=0.
- PEND update, in priority order:
  - evt[i] gives PEND[i] <= 1. Set beats a simultaneous clear, so no event is lost.
  - Otherwise clr[i] gives PEND[i] <= 0.
  - Otherwise PEND[i] holds.
- OVF update, in priority order:
  - evt[i] & PEND[i] & ~clr[i] gives OVF[i] <= 1. This is an event arriving on an already-pending, unacknowledged channel.
  - Otherwise clr[i] gives OVF[i] <= 0.
  - Otherwise OVF[i] holds.
  - An event coinciding with a clear of a pending channel is not an overrun.
- Masking:
  - MSK_WE gives MSK <= MSK_D.
  - Mask affects outputs only. Masked channels still capture PEND and OVF.
- Outputs:
  - Z* = PEND & ~MSK, purely combinational from registers, with no path from inputs to outputs.
  - PEND, OVF and MSK are driven directly from registers.
- No FSM beyond the per-channel 2-state pending flag (IDLE: PEND=0, PENDING: PEND=1).
  - IDLE to PENDING on evt.
  - PENDING to IDLE on clr & ~evt.

## Timing
- Reset (RST=1 at an edge) sets PREV=0, PEND=0, OVF=0, MSK=MSK_RST.
  - Resulting outputs: Z*=0, PEND=0, OVF=0, MSK=MSK_RST.
  - Reset overrides evt, CLR and MSK_WE in the same cycle.
- Input held high through reset deassertion: PREV=0, so with EDGE=1 the first non-reset edge captures an event.
- Latency:
  - Input sampled at edge k reaches PEND and Z* after edge k (1 cycle).
  - CLR at edge k drops PEND and Z* after edge k.
  - MSK_WE at edge k changes Z* after edge k.
- Reset mid-operation discards all pending and overrun state. No event is captured on the reset edge.
- EDGE=1 with an input held high: exactly one event. A clear while it is still held high does not re-set PEND.
- EDGE=0 with an input held high: clearing is ineffective, because set wins. Every edge while PEND=1 and no clear sets OVF.
- All five channels are independent. Simultaneous events on any subset are all captured in one cycle.

## Test plan
- Reset: RST=1 for 2 cycles with A..E=1 -> PEND=0, OVF=0, MSK=5'b11111, Z*=0. Release RST with A=1 (EDGE=1) -> PEND=5'b00001 after the first edge. ZA stays 0 (masked).
- Capture/mask: MSK_WE=1 with MSK_D=5'b00000. Pulse C for 1 cycle -> PEND=5'b00100 and ZC=1 one cycle later, held after C falls. Then MSK_D=5'b00100 -> ZC=0 with PEND unchanged.
- Clear: with PEND=5'b10101, CLR=1 and CLR_SEL=5'b00101 -> PEND=5'b10000. CLR_SEL=5'b11111 with CLR=0 -> no change.
- Set-vs-clear collision: PEND[1]=1, then a new B rising edge in the same cycle as CLR with CLR_SEL=5'b00010 -> PEND[1]=1, OVF[1]=0.
- Overrun: PEND[3]=1, then a second D rising edge with no clear -> OVF[3]=1. A subsequent clear of bit 3 -> PEND[3]=0 and OVF[3]=0.
- Level mode (EDGE=0): hold E high 3 cycles -> PEND[4]=1 after cycle 1, OVF[4]=1 after cycle 2. CLR of bit 4 while E is high -> PEND[4] stays 1.
